ahb_frame_reader: RTL and testbench
===================================

Name: ahb_frame_reader

Overview:
- AHB master read engine that sits directly downstream of the AHB bus interface.
- Fetches a contiguous image region from system memory using INCR4 word bursts and buffers the returned words in an internal FIFO.
- Presents the words to the edge-detector pixel pipeline over a valid/ready stream.
- Handles bus arbitration (hbusreq/hgrant), hready wait states and hresp ERROR aborts.

Parameters:
BUSWIDTH, 32, AHB address/data width in bits
FIFO_DEPTH, 8, word FIFO depth; power of 2, minimum 4
BURST_LEN, 4, beats per burst; fixed to INCR4 encoding

Ports:
ahb_hclk  input  1  bus clock; all logic on its rising edge
n_rst  input  1  synchronous active-low reset
start  input  1  one-cycle pulse, begin fetch; ignored while busy
base_addr  input  BUSWIDTH  start byte address; bits [3:0] forced to 0
num_bursts  input  14  INCR4 bursts to fetch; 0 -> immediate done
busy  output  1  fetch in progress
done  output  1  one-cycle pulse when the last word is pushed, or on the abort that ends a fetch
error  output  1  sticky; set on hresp ERROR, cleared by next accepted start
ahb_hbusreq  output  1  bus request
ahb_hgrant  input  1  bus grant
ahb_haddr  output  BUSWIDTH  address
ahb_htrans  output  2  IDLE=00, NONSEQ=10, SEQ=11
ahb_hburst  output  3  INCR4=011 during transfers, else 000
ahb_hsize  output  3  constant 010 (word)
ahb_hwrite  output  1  constant 0
ahb_hrdata  input  BUSWIDTH  read data
ahb_hready  input  1  transfer ready
ahb_hresp  input  1  0=OKAY, 1=ERROR
pix_data  output  BUSWIDTH  FIFO head word
pix_valid  output  1  FIFO non-empty
pix_ready  input  1  consumer accepts; pop when pix_valid&&pix_ready

Behaviour:
- Reset (n_rst=0 at the clock edge) sets:
  - state IDLE, FIFO empty;
  - busy=0, done=0, error=0, hbusreq=0;
  - htrans=IDLE, hburst=000, haddr=0;
  - pix_valid=0.
- Reset mid-burst abandons the transfer; the bus returns to IDLE on the next cycle.
- State machine:
  - IDLE: on start, latch addr=base_addr&~0xF and remaining=num_bursts, clear error, busy=1.
    - remaining==0 -> done pulse next cycle, stay IDLE.
    - Otherwise -> WAIT_SPACE.
  - WAIT_SPACE: hbusreq=0. When FIFO free slots >= 4 -> REQ.
  - REQ: hbusreq=1. When hgrant&&hready -> ADDR with beat=0.
  - ADDR: drive haddr=addr+4*beat, htrans=NONSEQ for beat 0 and SEQ otherwise, hburst=011. hbusreq stays high until beat 3 is issued.
    - Address and signals are held while hready=0.
    - When hready=1, beat increments.
    - After beat 3 is accepted -> DATA_LAST with htrans=IDLE.
  - DATA_LAST: wait for hready=1 to capture the beat-3 data. Then remaining--, addr+=16.
    - remaining==0 -> IDLE with done pulse and busy=0.
    - Otherwise -> WAIT_SPACE.
  - Losing hgrant mid-burst is not supported; the arbiter must not revoke grant inside an INCR4.
- Data capture: the data phase follows the address phase by one accepted cycle. ahb_hrdata is pushed to the FIFO on each cycle where a data phase is active and hready=1 and hresp=0.
  - The FIFO cannot overflow: a burst only starts with >=4 free slots, and the consumer pops only reduce occupancy.
- Error: hresp=1 during a data phase (either cycle of the two-cycle response):
  - set error, drop that beat;
  - drive htrans=IDLE on the next cycle (cancel remaining beats);
  - drop hbusreq, go to IDLE with done pulse.
  - Words already in the FIFO remain poppable.
- FIFO:
  - pointers are log2(FIFO_DEPTH)+1 bits with wrap bit;
  - a simultaneous push and pop keeps the count unchanged;
  - a pop when empty is ignored;
  - pix_data is registered at the head, with zero bubble on back-to-back pops.
- start while busy is ignored (no state change, error not cleared).

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ;
  - HBURST_SINGLE/INCR4;
  - HSIZE_WORD;
  - HRESP_OKAY/ERROR;
  - the reader state enum.
- One sub-module, word_fifo (parameterised BUSWIDTH, FIFO_DEPTH), with push/pop/full/empty/count ports.

Test Plan:
1. Zero wait states, grant immediate. start, base_addr=0x1000, num_bursts=2, pix_ready=1 -> haddr 0x1000..0x101C, htrans 10,11,11,11 twice; 8 words out in order; done pulses once; busy falls the same cycle.
2. base_addr=0x2007 -> first haddr=0x2000.
3. hready low for 3 cycles on beat 1 -> haddr and htrans held; data still captured exactly once per beat.
4. pix_ready=0, FIFO_DEPTH=8, num_bursts=3 -> two bursts complete, FIFO full (8), third burst waits with hbusreq=0. Raising pix_ready frees 4 slots -> third burst starts; 12 words total.
5. hresp=1 on beat 2 of burst 1 -> error=1, only beats 0-1 in the FIFO, htrans=IDLE, done pulse. A later start clears error.
6. Reset asserted mid-ADDR -> next cycle htrans=00, hbusreq=0, pix_valid=0, busy=0. start with num_bursts=0 -> done pulse, no bus activity.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-lite encodings and the frame reader state type
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SPACE,
    S_REQ,
    S_ADDR,
    S_DATA_LAST
  } rd_state_e;
endpackage

// File: rtl/word_fifo.sv
// word_fifo: word FIFO with wrap-bit pointers and a registered head word
module word_fifo #(
  parameter int BUSWIDTH   = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          push_i,
  input  logic [BUSWIDTH-1:0]           wdata_i,
  input  logic                          pop_i,
  output logic [BUSWIDTH-1:0]           rdata_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [BUSWIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]         wr_q, rd_q, rd_d;
  logic [BUSWIDTH-1:0] head_q, head_d;
  logic                do_push, do_pop;
  assign count_o = wr_q - rd_q;
  assign empty_o = wr_q == rd_q;
  assign full_o  = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = head_q;
  // The head register bypasses the write port when the pushed word becomes the new head.
  always_comb begin
    rd_d   = rd_q + (AW+1)'(do_pop);
    head_d = (do_push && wr_q == rd_d) ? wdata_i : do_pop ? mem_q[rd_d[AW-1:0]] : head_q;
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_q + (AW+1)'(do_push);
      rd_q   <= rd_d;
      head_q <= head_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/ahb_frame_reader.sv
// ahb_frame_reader: AHB INCR4 read engine feeding a word FIFO to a valid/ready pixel stream
module ahb_frame_reader
  import ahb_pkg::*;
#(
  parameter int BUSWIDTH   = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                ahb_hclk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [BUSWIDTH-1:0] base_addr,
  input  logic [13:0]         num_bursts,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                ahb_hbusreq,
  input  logic                ahb_hgrant,
  output logic [BUSWIDTH-1:0] ahb_haddr,
  output logic [1:0]          ahb_htrans,
  output logic [2:0]          ahb_hburst,
  output logic [2:0]          ahb_hsize,
  output logic                ahb_hwrite,
  input  logic [BUSWIDTH-1:0] ahb_hrdata,
  input  logic                ahb_hready,
  input  logic                ahb_hresp,
  output logic [BUSWIDTH-1:0] pix_data,
  output logic                pix_valid,
  input  logic                pix_ready
);
  localparam logic [1:0] LAST_BEAT = 2'(BURST_LEN - 1);
  rd_state_e                   state_q, state_d;
  logic [BUSWIDTH-1:0]         addr_q, addr_d;
  logic [13:0]                 rem_q, rem_d;
  logic [1:0]                  beat_q, beat_d;
  logic                        dph_q, dph_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic                        abort, push, space_ok, fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  assign abort    = dph_q && ahb_hresp == HRESP_ERROR;
  assign push     = dph_q && ahb_hready && ahb_hresp == HRESP_OKAY;
  assign space_ok = (FIFO_DEPTH - int'(fifo_count)) >= BURST_LEN;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    beat_d  = beat_q;
    dph_d   = ahb_hready ? 1'b0 : dph_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        addr_d  = base_addr & ~(BUSWIDTH'(4'hF));
        rem_d   = num_bursts;
        err_d   = 1'b0;
        done_d  = num_bursts == '0;
        state_d = num_bursts == '0 ? S_IDLE : S_WAIT_SPACE;
      end
      S_WAIT_SPACE: state_d = space_ok ? S_REQ : S_WAIT_SPACE;
      S_REQ: if (ahb_hgrant && ahb_hready) begin
        state_d = S_ADDR;
        beat_d  = '0;
      end
      S_ADDR: if (abort) begin
        err_d   = 1'b1;
        done_d  = 1'b1;
        dph_d   = 1'b0;
        state_d = S_IDLE;
      end else if (ahb_hready) begin
        dph_d   = 1'b1;
        beat_d  = beat_q + 2'd1;
        state_d = beat_q == LAST_BEAT ? S_DATA_LAST : S_ADDR;
      end
      S_DATA_LAST: if (abort) begin
        err_d   = 1'b1;
        done_d  = 1'b1;
        dph_d   = 1'b0;
        state_d = S_IDLE;
      end else if (ahb_hready) begin
        rem_d   = rem_q - 14'd1;
        addr_d  = addr_q + BUSWIDTH'(BURST_LEN * 4);
        done_d  = rem_q == 14'd1;
        state_d = rem_q == 14'd1 ? S_IDLE : S_WAIT_SPACE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge ahb_hclk) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
      dph_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      beat_q  <= beat_d;
      dph_q   <= dph_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign busy        = state_q != S_IDLE;
  assign done        = done_q;
  assign error       = err_q;
  assign ahb_hbusreq = state_q == S_REQ || state_q == S_ADDR;
  assign ahb_htrans  = state_q != S_ADDR ? HTRANS_IDLE : beat_q == '0 ? HTRANS_NONSEQ : HTRANS_SEQ;
  assign ahb_hburst  = state_q == S_ADDR ? HBURST_INCR4 : HBURST_SINGLE;
  assign ahb_haddr   = state_q == S_ADDR ? addr_q + BUSWIDTH'({beat_q, 2'b00}) : '0;
  assign ahb_hsize   = HSIZE_WORD;
  assign ahb_hwrite  = 1'b0;
  assign pix_valid   = !fifo_empty;
  word_fifo #(
    .BUSWIDTH  (BUSWIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (ahb_hclk),
    .n_rst  (n_rst),
    .push_i (push),
    .wdata_i(ahb_hrdata),
    .pop_i  (pix_valid && pix_ready),
    .rdata_o(pix_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );
endmodule

// File: tb/tb_ahb_frame_reader.sv
// tb_ahb_frame_reader: directed bench with an address-derived AHB slave and popped-word log
module tb_ahb_frame_reader;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic        ahb_hclk = 1'b0;
  logic        n_rst, start, ahb_hgrant, ahb_hready, ahb_hresp, pix_ready;
  logic [31:0] base_addr, ahb_hrdata, ahb_haddr, pix_data;
  logic [13:0] num_bursts;
  logic        busy, done, error, ahb_hbusreq, ahb_hwrite, pix_valid;
  logic [1:0]  ahb_htrans;
  logic [2:0]  ahb_hburst, ahb_hsize;
  logic [31:0] dp_addr = '0;
  logic [31:0] got[$];
  logic [31:0] tr_addr[$];
  logic [1:0]  tr_trans[$];
  int          tests = 0, failed = 0, done_cnt = 0;

  always #5 ahb_hclk = ~ahb_hclk;

  ahb_frame_reader dut (
    .ahb_hclk(ahb_hclk), .n_rst(n_rst), .start(start), .base_addr(base_addr),
    .num_bursts(num_bursts), .busy(busy), .done(done), .error(error),
    .ahb_hbusreq(ahb_hbusreq), .ahb_hgrant(ahb_hgrant), .ahb_haddr(ahb_haddr),
    .ahb_htrans(ahb_htrans), .ahb_hburst(ahb_hburst), .ahb_hsize(ahb_hsize),
    .ahb_hwrite(ahb_hwrite), .ahb_hrdata(ahb_hrdata), .ahb_hready(ahb_hready),
    .ahb_hresp(ahb_hresp), .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready)
  );

  // Slave returns a word derived from the address whose data phase is active.
  always @(posedge ahb_hclk) if (ahb_hready) dp_addr <= ahb_haddr;
  assign ahb_hrdata = dp_addr ^ K;

  always @(posedge ahb_hclk) begin
    if (n_rst && pix_valid && pix_ready) got.push_back(pix_data);
    if (n_rst && ahb_htrans[1] && ahb_hready) begin
      tr_addr.push_back(ahb_haddr);
      tr_trans.push_back(ahb_htrans);
    end
    if (n_rst && done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [31:0] a, input logic [13:0] nb);
    base_addr  = a;
    num_bursts = nb;
    start      = 1'b1;
    @(negedge ahb_hclk);
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 200) begin
      @(negedge ahb_hclk);
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic chk_words(input string tag, input logic [31:0] base, input int nw);
    chk({tag, "_count"}, 32'(got.size()), 32'(nw));
    for (int i = 0; i < nw && i < got.size(); i++)
      chk(tag, got[i], (base + 32'(4 * i)) ^ K);
  endtask

  task automatic chk_trace(input string tag, input logic [31:0] base, input int nb);
    chk({tag, "_count"}, 32'(tr_addr.size()), 32'(4 * nb));
    for (int i = 0; i < 4 * nb && i < tr_addr.size(); i++) begin
      chk({tag, "_addr"}, tr_addr[i], base + 32'(4 * i));
      chk({tag, "_trans"}, 32'(tr_trans[i]), (i % 4 == 0) ? 32'h2 : 32'h3);
    end
  endtask

  task automatic clear_logs();
    got.delete();
    tr_addr.delete();
    tr_trans.delete();
    done_cnt = 0;
  endtask

  initial begin
    int n;
    n_rst = 1'b0; start = 1'b0; base_addr = '0; num_bursts = '0;
    ahb_hgrant = 1'b1; ahb_hready = 1'b1; ahb_hresp = 1'b0; pix_ready = 1'b1;
    repeat (3) @(negedge ahb_hclk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_hbusreq", 32'(ahb_hbusreq), 0);
    chk("rst_htrans", 32'(ahb_htrans), 0);
    chk("rst_hburst", 32'(ahb_hburst), 0);
    chk("rst_haddr", ahb_haddr, 0);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("hsize", 32'(ahb_hsize), 32'h2);
    chk("hwrite", 32'(ahb_hwrite), 0);
    n_rst = 1'b1;
    @(negedge ahb_hclk);

    // 1: two bursts, no wait states
    clear_logs();
    go(32'h1000, 14'd2);
    chk("t1_busy", 32'(busy), 1);
    wait_done("t1_done");
    chk("t1_busy_fall", 32'(busy), 0);
    repeat (10) @(negedge ahb_hclk);
    chk("t1_done_once", 32'(done_cnt), 1);
    chk_trace("t1", 32'h1000, 2);
    chk_words("t1_word", 32'h1000, 8);

    // 2: unaligned base is aligned down
    clear_logs();
    go(32'h2007, 14'd1);
    wait_done("t2_done");
    repeat (10) @(negedge ahb_hclk);
    chk_trace("t2", 32'h2000, 1);
    chk_words("t2_word", 32'h2000, 4);

    // 3: three wait states on beat 1
    clear_logs();
    go(32'h3000, 14'd1);
    n = 0;
    while (ahb_htrans != 2'b11 && n < 50) begin @(negedge ahb_hclk); n++; end
    chk("t3_seq_seen", 32'(ahb_htrans), 32'h3);
    ahb_hready = 1'b0;
    repeat (3) begin
      @(negedge ahb_hclk);
      chk("t3_hold_addr", ahb_haddr, 32'h3004);
      chk("t3_hold_trans", 32'(ahb_htrans), 32'h3);
    end
    ahb_hready = 1'b1;
    wait_done("t3_done");
    repeat (10) @(negedge ahb_hclk);
    chk_trace("t3", 32'h3000, 1);
    chk_words("t3_word", 32'h3000, 4);

    // 4: consumer stalled, FIFO fills, third burst waits for space
    clear_logs();
    pix_ready = 1'b0;
    go(32'h4000, 14'd3);
    repeat (40) @(negedge ahb_hclk);
    chk("t4_busy", 32'(busy), 1);
    chk("t4_hbusreq", 32'(ahb_hbusreq), 0);
    chk("t4_htrans", 32'(ahb_htrans), 0);
    chk("t4_addr_count", 32'(tr_addr.size()), 8);
    chk("t4_valid", 32'(pix_valid), 1);
    chk("t4_head", pix_data, 32'h4000 ^ K);
    pix_ready = 1'b1;
    wait_done("t4_done");
    repeat (15) @(negedge ahb_hclk);
    chk_trace("t4", 32'h4000, 3);
    chk_words("t4_word", 32'h4000, 12);

    // 5: ERROR on beat 2 of the first burst
    clear_logs();
    pix_ready = 1'b0;
    go(32'h5000, 14'd2);
    n = 0;
    while (!(ahb_haddr == 32'h500C && ahb_htrans == 2'b11) && n < 50) begin @(negedge ahb_hclk); n++; end
    chk("t5_beat3_seen", ahb_haddr, 32'h500C);
    ahb_hresp  = 1'b1;
    ahb_hready = 1'b0;
    @(negedge ahb_hclk);
    chk("t5_error", 32'(error), 1);
    chk("t5_done", 32'(done), 1);
    chk("t5_htrans", 32'(ahb_htrans), 0);
    chk("t5_hbusreq", 32'(ahb_hbusreq), 0);
    chk("t5_busy", 32'(busy), 0);
    ahb_hready = 1'b1;
    @(negedge ahb_hclk);
    ahb_hresp = 1'b0;
    chk("t5_sticky", 32'(error), 1);
    pix_ready = 1'b1;
    repeat (6) @(negedge ahb_hclk);
    chk_words("t5_word", 32'h5000, 2);
    // Restart clears error; a second start while busy is ignored
    clear_logs();
    go(32'h6000, 14'd1);
    chk("t5_err_clear", 32'(error), 0);
    go(32'h7000, 14'd1);
    wait_done("t5b_done");
    repeat (10) @(negedge ahb_hclk);
    chk("t5b_done_once", 32'(done_cnt), 1);
    chk_trace("t5b", 32'h6000, 1);

    // 6: reset in the second burst's address phase, then an empty fetch
    clear_logs();
    pix_ready = 1'b0;
    go(32'h8000, 14'd2);
    n = 0;
    while (!(ahb_haddr == 32'h8010 && ahb_htrans == 2'b10) && n < 60) begin @(negedge ahb_hclk); n++; end
    chk("t6_nonseq_seen", ahb_haddr, 32'h8010);
    chk("t6_valid_before", 32'(pix_valid), 1);
    n_rst = 1'b0;
    @(negedge ahb_hclk);
    chk("t6_htrans", 32'(ahb_htrans), 0);
    chk("t6_hbusreq", 32'(ahb_hbusreq), 0);
    chk("t6_pix_valid", 32'(pix_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    n_rst = 1'b1;
    @(negedge ahb_hclk);
    clear_logs();
    go(32'h9000, 14'd0);
    chk("t6_zero_done", 32'(done), 1);
    chk("t6_zero_busy", 32'(busy), 0);
    repeat (8) @(negedge ahb_hclk);
    chk("t6_zero_bus", 32'(tr_addr.size()), 0);
    chk("t6_zero_once", 32'(done_cnt), 1);
    chk("t6_zero_hbusreq", 32'(ahb_hbusreq), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
